// File: rtl/alu_issue_queue_pkg.sv
// Shared constants for the ALU issue stage: default width, opcode codes, legality check.
package alu_issue_queue_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  // ALU operation codes; shared with the ALU datapath.
  localparam logic [3:0] ALUC_ADD = 4'h0;
  localparam logic [3:0] ALUC_SUB = 4'h1;
  localparam logic [3:0] ALUC_AND = 4'h2;
  localparam logic [3:0] ALUC_OR  = 4'h3;
  localparam logic [3:0] ALUC_XOR = 4'h4;
  localparam logic [3:0] ALUC_LUI = 4'h5;
  localparam logic [3:0] ALUC_SLL = 4'h6;
  localparam logic [3:0] ALUC_SRL = 4'h7;
  localparam logic [3:0] ALUC_SRA = 4'h8;

  // True when op is one of the codes the ALU actually implements.
  function automatic logic aluc_legal(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      ALUC_ADD, ALUC_SUB, ALUC_AND, ALUC_OR, ALUC_XOR,
      ALUC_LUI, ALUC_SLL, ALUC_SRL, ALUC_SRA: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_issue_queue_cmd_fifo.sv
// In-order command FIFO with show-ahead head output. Pointers carry one extra
// wrap bit so full and empty can be told apart without a counter.
module alu_cmd_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage; flush empties the queue and wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = wdata;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Pointer and storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue stage in front of the combinational ALU: queues commands, drives the
// FIFO head onto the ALU bus, and captures the ALU outputs into a result slot.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. Valid, once raised by a producer, is held with stable payload until the
// transfer; ready may change freely and never depends on the same-side valid.
// in_ready = !full (forced high during flush, when any offered command is dropped);
// res_valid/res_data are held stable until res_ready is seen.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_opcode,
  input  logic [DATA_WIDTH-1:0] in_dina,
  input  logic [DATA_WIDTH-1:0] in_dinb,
  input  logic                  in_fwd_a,
  output logic [DATA_WIDTH-1:0] alu_dina,
  output logic [DATA_WIDTH-1:0] alu_dinb,
  output logic [3:0]            alu_opcode,
  input  logic [DATA_WIDTH-1:0] alu_doutr,
  input  logic                  alu_doutz,
  input  logic                  alu_flag_of,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_zero,
  output logic                  res_of,
  output logic                  res_err,
  output logic [CNT_WIDTH-1:0]  of_count
);

  localparam int CMD_W = 4 + 2 * DATA_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Command word layout: {opcode, dina, dinb, fwd_a}.
  logic [CMD_W-1:0]      push_word;
  logic [CMD_W-1:0]      head_word;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  issue;
  logic [3:0]            head_op;
  logic [DATA_WIDTH-1:0] head_dina;
  logic [DATA_WIDTH-1:0] head_dinb;
  logic                  head_fwd;
  logic                  head_legal;

  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q,  res_data_d;
  logic                  res_zero_q,  res_zero_d;
  logic                  res_of_q,    res_of_d;
  logic                  res_err_q,   res_err_d;
  logic [DATA_WIDTH-1:0] last_result_q, last_result_d;
  logic [CNT_WIDTH-1:0]  of_count_q,  of_count_d;

  assign push_word = {in_opcode, in_dina, in_dinb, in_fwd_a};
  assign {head_op, head_dina, head_dinb, head_fwd} = head_word;
  assign head_legal = aluc_legal(head_op);

  // A pop in the same cycle does not open a slot for a full FIFO.
  assign in_ready = !fifo_full || flush;
  assign push     = in_valid && !fifo_full && !flush;
  assign issue    = !fifo_empty && (!res_valid_q || res_ready) && !flush;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (issue),
    .wdata (push_word),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ALU bus from the head; idle or undefined opcodes present a harmless ADD 0,0.
  always_comb begin
    alu_opcode = 4'h0;
    alu_dina   = '0;
    alu_dinb   = '0;
    if (!fifo_empty) begin
      if (head_legal) begin
        alu_opcode = head_op;
        alu_dina   = head_fwd ? last_result_q : head_dina;
        alu_dinb   = head_dinb;
      end else begin
        alu_opcode = ALUC_ADD;
      end
    end
  end

  // Result slot, chaining register and overflow counter updates.
  always_comb begin
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_zero_d    = res_zero_q;
    res_of_d      = res_of_q;
    res_err_d     = res_err_q;
    last_result_d = last_result_q;
    of_count_d    = of_count_q;
    if (flush) begin
      res_valid_d = 1'b0;
    end else if (issue) begin
      res_valid_d = 1'b1;
      if (head_legal) begin
        res_data_d    = alu_doutr;
        res_zero_d    = alu_doutz;
        res_of_d      = alu_flag_of;
        res_err_d     = 1'b0;
        last_result_d = alu_doutr;
        if (alu_flag_of && !(&of_count_q)) begin
          of_count_d = of_count_q + CNT_ONE;
        end
      end else begin
        res_data_d = '0;
        res_zero_d = 1'b1;
        res_of_d   = 1'b0;
        res_err_d  = 1'b1;
      end
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // State registers for the result slot and bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_zero_q    <= 1'b0;
      res_of_q      <= 1'b0;
      res_err_q     <= 1'b0;
      last_result_q <= '0;
      of_count_q    <= '0;
    end else begin
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_zero_q    <= res_zero_d;
      res_of_q      <= res_of_d;
      res_err_q     <= res_err_d;
      last_result_q <= last_result_d;
      of_count_q    <= of_count_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_of    = res_of_q;
  assign res_err   = res_err_q;
  assign of_count  = of_count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural ALU closing the loop.
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int DW = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_opcode = 4'h0;
  logic [DW-1:0] in_dina = '0;
  logic [DW-1:0] in_dinb = '0;
  logic          in_fwd_a = 1'b0;
  logic [DW-1:0] alu_dina, alu_dinb, alu_doutr;
  logic [3:0]    alu_opcode;
  logic          alu_doutz, alu_flag_of;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          res_zero, res_of, res_err;
  logic [CW-1:0] of_count;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  alu_issue_queue #(.DATA_WIDTH(DW), .DEPTH(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_dina(in_dina), .in_dinb(in_dinb), .in_fwd_a(in_fwd_a),
    .alu_dina(alu_dina), .alu_dinb(alu_dinb), .alu_opcode(alu_opcode),
    .alu_doutr(alu_doutr), .alu_doutz(alu_doutz), .alu_flag_of(alu_flag_of),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_of(res_of), .res_err(res_err), .of_count(of_count)
  );

  // Behavioural ALU: flag_of is carry-out for ADD, borrow for SUB.
  logic [DW:0] alu_wide;
  always_comb begin
    alu_doutr   = '0;
    alu_flag_of = 1'b0;
    alu_wide    = '0;
    case (alu_opcode)
      ALUC_ADD: begin
        alu_wide = {1'b0, alu_dina} + {1'b0, alu_dinb};
        alu_doutr = alu_wide[DW-1:0];
        alu_flag_of = alu_wide[DW];
      end
      ALUC_SUB: begin
        alu_wide = {1'b0, alu_dina} - {1'b0, alu_dinb};
        alu_doutr = alu_wide[DW-1:0];
        alu_flag_of = alu_wide[DW];
      end
      ALUC_AND: alu_doutr = alu_dina & alu_dinb;
      ALUC_OR:  alu_doutr = alu_dina | alu_dinb;
      ALUC_XOR: alu_doutr = alu_dina ^ alu_dinb;
      ALUC_LUI: alu_doutr = {alu_dinb[3:0], 4'h0};
      ALUC_SLL: alu_doutr = alu_dinb << alu_dina[2:0];
      ALUC_SRL: alu_doutr = alu_dinb >> alu_dina[2:0];
      ALUC_SRA: alu_doutr = $unsigned($signed(alu_dinb) >>> alu_dina[2:0]);
      default:  alu_doutr = '0;
    endcase
  end
  assign alu_doutz = (alu_doutr == '0);

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic fwd);
    in_valid  = 1'b1;
    in_opcode = op;
    in_dina   = a;
    in_dinb   = b;
    in_fwd_a  = fwd;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b exp 0", res_valid); end
    n_checks++; if ({res_data, res_zero, res_of, res_err} !== 11'h0) begin n_fail++; $display("FAIL reset_res_fields: got %h/%b/%b/%b exp 0", res_data, res_zero, res_of, res_err); end
    n_checks++; if (of_count !== 3'd0) begin n_fail++; $display("FAIL reset_of_count: got %0d exp 0", of_count); end
    n_checks++; if ({alu_opcode, alu_dina, alu_dinb} !== 20'h0) begin n_fail++; $display("FAIL reset_alu_bus: got %h %h %h exp 0", alu_opcode, alu_dina, alu_dinb); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    res_ready = 1'b1;
    set_cmd(ALUC_ADD, 8'h05, 8'h03, 1'b0);
    step();
    idle();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: got %b exp 0", res_valid); end
    step();
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b exp 1", res_valid); end
    n_checks++; if (res_data !== 8'h08) begin n_fail++; $display("FAIL basic_data: got %h exp 08", res_data); end
    n_checks++; if ({res_zero, res_of, res_err} !== 3'b000) begin n_fail++; $display("FAIL basic_flags: got %b exp 000", {res_zero, res_of, res_err}); end
    step();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consume: got %b exp 0", res_valid); end
  endtask

  task automatic test_chain();
    res_ready = 1'b1;
    set_cmd(ALUC_ADD, 8'h10, 8'h01, 1'b0);
    step();
    set_cmd(ALUC_ADD, 8'hEE, 8'h01, 1'b1);
    step();
    n_checks++; if (res_data !== 8'h11) begin n_fail++; $display("FAIL chain_r0: got %h exp 11", res_data); end
    set_cmd(ALUC_SUB, 8'hEE, 8'h12, 1'b1);
    step();
    n_checks++; if (res_data !== 8'h12) begin n_fail++; $display("FAIL chain_r1: got %h exp 12", res_data); end
    idle();
    step();
    n_checks++; if (res_data !== 8'h00 || res_zero !== 1'b1 || res_valid !== 1'b1) begin n_fail++; $display("FAIL chain_r2: got %h z=%b v=%b exp 00 z=1 v=1", res_data, res_zero, res_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_cmd(ALUC_ADD, 8'(i + 1), 8'h10, 1'b0);
      step();
    end
    idle();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b exp 0", in_ready); end
    set_cmd(ALUC_ADD, 8'h99, 8'h00, 1'b0);
    step();
    idle();
    n_checks++; if (res_valid !== 1'b1 || res_data !== 8'h11) begin n_fail++; $display("FAIL bp_hold: got v=%b %h exp v=1 11", res_valid, res_data); end
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (res_valid !== 1'b1 || res_data !== 8'(8'h11 + i)) begin n_fail++; $display("FAIL bp_order%0d: got v=%b %h exp v=1 %h", i, res_valid, res_data, 8'(8'h11 + i)); end
      step();
    end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra: got %b exp 0", res_valid); end
  endtask

  task automatic test_illegal();
    res_ready = 1'b1;
    set_cmd(ALUC_ADD, 8'h20, 8'h02, 1'b0);
    step();
    set_cmd(4'hF, 8'h55, 8'h66, 1'b0);
    step();
    n_checks++; if (res_data !== 8'h22) begin n_fail++; $display("FAIL ill_prior: got %h exp 22", res_data); end
    n_checks++; if ({alu_opcode, alu_dina, alu_dinb} !== {ALUC_ADD, 16'h0}) begin n_fail++; $display("FAIL ill_bus: got %h %h %h exp %h 00 00", alu_opcode, alu_dina, alu_dinb, ALUC_ADD); end
    set_cmd(ALUC_ADD, 8'h77, 8'h01, 1'b1);
    step();
    n_checks++; if ({res_err, res_data, res_zero, res_of} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin n_fail++; $display("FAIL ill_result: got err=%b %h z=%b of=%b exp err=1 00 z=1 of=0", res_err, res_data, res_zero, res_of); end
    idle();
    step();
    n_checks++; if (res_data !== 8'h23 || res_err !== 1'b0) begin n_fail++; $display("FAIL ill_fwd_after: got %h err=%b exp 23 err=0", res_data, res_err); end
    step();
    n_checks++; if (of_count !== 3'd0) begin n_fail++; $display("FAIL ill_of_count: got %0d exp 0", of_count); end
  endtask

  task automatic test_overflow();
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_cmd(ALUC_ADD, 8'hFF, 8'h01, 1'b0);
      step();
      if (i > 0) begin
        n_checks++; if (res_of !== 1'b1 || res_data !== 8'h00) begin n_fail++; $display("FAIL of_each%0d: got of=%b %h exp of=1 00", i, res_of, res_data); end
      end
    end
    idle();
    step();
    n_checks++; if (res_of !== 1'b1 || of_count !== 3'd3) begin n_fail++; $display("FAIL of_three: got of=%b cnt=%0d exp of=1 cnt=3", res_of, of_count); end
    step();
    for (int i = 0; i < 5; i++) begin
      set_cmd(ALUC_ADD, 8'hFF, 8'h01, 1'b0);
      step();
    end
    idle();
    step();
    n_checks++; if (of_count !== 3'd7) begin n_fail++; $display("FAIL of_saturate: got %0d exp 7", of_count); end
    set_cmd(ALUC_ADD, 8'hFF, 8'h01, 1'b0);
    step();
    idle();
    step();
    n_checks++; if (of_count !== 3'd7 || res_of !== 1'b1) begin n_fail++; $display("FAIL of_hold_max: got cnt=%0d of=%b exp cnt=7 of=1", of_count, res_of); end
    step();
  endtask

  task automatic test_flush();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_cmd(ALUC_ADD, 8'h30, 8'h01, 1'b0);
      step();
    end
    idle();
    n_checks++; if (in_ready !== 1'b0 || res_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got rdy=%b v=%b exp rdy=0 v=1", in_ready, res_valid); end
    flush = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b exp 1", in_ready); end
    step();
    flush = 1'b0;
    #1;
    n_checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_clear: got v=%b rdy=%b exp v=0 rdy=1", res_valid, in_ready); end
    n_checks++; if ({alu_opcode, alu_dinb} !== 12'h0) begin n_fail++; $display("FAIL flush_empty: got op=%h b=%h exp 0", alu_opcode, alu_dinb); end
    n_checks++; if (of_count !== 3'd7) begin n_fail++; $display("FAIL flush_keep_cnt: got %0d exp 7", of_count); end
    res_ready = 1'b1;
    set_cmd(ALUC_ADD, 8'h00, 8'h01, 1'b1);
    step();
    idle();
    step();
    n_checks++; if (res_valid !== 1'b1 || res_data !== 8'h32) begin n_fail++; $display("FAIL flush_keep_last: got v=%b %h exp v=1 32", res_valid, res_data); end
    step();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_stale: got %b exp 0", res_valid); end
  endtask

  task automatic test_rst_mid();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(ALUC_ADD, 8'h40, 8'h01, 1'b0);
      step();
    end
    idle();
    rst = 1'b1;
    #1;
    n_checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_hs: got v=%b rdy=%b exp v=0 rdy=1", res_valid, in_ready); end
    n_checks++; if ({res_data, res_zero, res_of, res_err} !== 11'h0 || of_count !== 3'd0) begin n_fail++; $display("FAIL rst_mid_fields: got %h/%b/%b/%b cnt=%0d exp 0", res_data, res_zero, res_of, res_err, of_count); end
    n_checks++; if ({alu_opcode, alu_dina, alu_dinb} !== 20'h0) begin n_fail++; $display("FAIL rst_mid_bus: got %h %h %h exp 0", alu_opcode, alu_dina, alu_dinb); end
    step();
    rst = 1'b0;
    res_ready = 1'b1;
    set_cmd(ALUC_ADD, 8'hAA, 8'h05, 1'b1);
    step();
    idle();
    step();
    n_checks++; if (res_valid !== 1'b1 || res_data !== 8'h05) begin n_fail++; $display("FAIL rst_mid_last0: got v=%b %h exp v=1 05", res_valid, res_data); end
    step();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_discard: got %b exp 0", res_valid); end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_chain();
    test_back_to_back();
    test_illegal();
    test_overflow();
    test_flush();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
